// File: rtl/postnet_frame_rx.sv
// postnet_frame_rx
//   Assembles two-out-of-five code words into a frame of NDIG BCD data digits
//   plus one mod-10 check digit. The frame and its error status are held on a
//   valid/ready handshake. Frames delivered with an error are counted in a
//   saturating 8-bit counter.
// Ports
//   CLK, RST_N            clock (rising edge) and async active-low reset
//   CODE_IN/DET_IN        code word and detector flag (1 = code error)
//   IN_SOF/IN_VALID       first-word marker and word valid
//   IN_READY              word accepted this cycle (0 while a frame is held)
//   FRAME                 packed BCD digits, first digit in the top nibble
//   FRAME_ERR             [0] code error, [1] checksum mismatch
//   FRAME_VALID/_READY    frame handshake
//   ERR_CNT               delivered errored frames, saturating at 255
module postnet_frame_rx #(
  parameter int NDIG = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [4:0]        CODE_IN,
  input  logic              DET_IN,
  input  logic              IN_SOF,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [4*NDIG-1:0] FRAME,
  output logic [1:0]        FRAME_ERR,
  output logic              FRAME_VALID,
  input  logic              FRAME_READY,
  output logic [7:0]        ERR_CNT
);

  localparam int          W    = 4 * NDIG;
  localparam logic [3:0]  LAST = 4'(NDIG);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     sum_q, sum_d;
  logic           cerr_q, cerr_d;
  logic [W-1:0]   frame_q, frame_d;
  logic [1:0]     err_q, err_d;
  logic [7:0]     cnt_q, cnt_d;

  function automatic logic [3:0] decode(input logic [4:0] c);
    logic [3:0] d;
    case (c)
      5'b11000: d = 4'd0;
      5'b00011: d = 4'd1;
      5'b00101: d = 4'd2;
      5'b00110: d = 4'd3;
      5'b01001: d = 4'd4;
      5'b01010: d = 4'd5;
      5'b01100: d = 4'd6;
      5'b10001: d = 4'd7;
      5'b10010: d = 4'd8;
      5'b10100: d = 4'd9;
      default:  d = 4'd0;
    endcase
    return d;
  endfunction

  logic           accept;
  logic           restart;
  logic [3:0]     dig;
  logic [3:0]     sum_base;
  logic [4:0]     sum5;
  logic [3:0]     sum_new;
  logic           cerr_new;
  logic [W+3:0]   shifted;

  assign IN_READY    = (state_q != HOLD);
  assign FRAME_VALID = (state_q == HOLD);
  assign FRAME       = frame_q;
  assign FRAME_ERR   = err_q;
  assign ERR_CNT     = cnt_q;

  // Running-sum / error update shared by the first word and later words;
  // an SOF word always starts from a clean sum and error flag.
  assign accept   = IN_VALID & IN_READY;
  assign restart  = accept & IN_SOF;
  assign dig      = DET_IN ? 4'd0 : decode(CODE_IN);
  assign sum_base = restart ? 4'd0 : sum_q;
  assign sum5     = {1'b0, sum_base} + {1'b0, dig};
  assign sum_new  = (sum5 >= 5'd10) ? 4'(sum5 - 5'd10) : sum5[3:0];
  assign cerr_new = restart ? DET_IN : (cerr_q | DET_IN);
  // Widened shift keeps the slice legal for NDIG == 1.
  assign shifted  = {frame_q, dig};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cerr_d  = cerr_q;
    frame_d = frame_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Non-SOF words here are consumed and dropped.
        if (restart) begin
          state_d = COLLECT;
          idx_d   = 4'd1;
          sum_d   = sum_new;
          cerr_d  = cerr_new;
          frame_d = shifted[W-1:0];
        end
      end
      COLLECT: begin
        if (accept) begin
          sum_d  = sum_new;
          cerr_d = cerr_new;
          if (IN_SOF) begin
            idx_d   = 4'd1;
            frame_d = shifted[W-1:0];
          end else begin
            if (idx_q < LAST) frame_d = shifted[W-1:0];
            if (idx_q == LAST) begin
              state_d = HOLD;
              idx_d   = 4'd0;
              err_d   = {(sum_new != 4'd0) & ~cerr_new, cerr_new};
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end
      HOLD: begin
        if (FRAME_READY) begin
          state_d = IDLE;
          if ((err_q != 2'b00) && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      cerr_q  <= 1'b0;
      frame_q <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cerr_q  <= cerr_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_postnet_frame_rx.sv
module tb_postnet_frame_rx;
  localparam int NDIG = 5;
  localparam int W    = 4 * NDIG;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [4:0]   CODE_IN = '0;
  logic         DET_IN = 1'b0;
  logic         IN_SOF = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] FRAME;
  logic [1:0]   FRAME_ERR;
  logic         FRAME_VALID;
  logic         FRAME_READY = 1'b0;
  logic [7:0]   ERR_CNT;

  postnet_frame_rx #(.NDIG(NDIG)) dut (
    .CLK(CLK), .RST_N(RST_N), .CODE_IN(CODE_IN), .DET_IN(DET_IN),
    .IN_SOF(IN_SOF), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .FRAME(FRAME), .FRAME_ERR(FRAME_ERR), .FRAME_VALID(FRAME_VALID),
    .FRAME_READY(FRAME_READY), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] frame;
    logic [1:0]   err;
    int           cnt;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         model_cnt = 0;
  logic [4:0] enc[10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                          5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};
  logic [4:0] w_code[NDIG+1];
  logic       w_det[NDIG+1];
  bit         bp = 1'b0;
  bit         bp_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decode each word by table lookup, build the digit list,
  // and judge the frame by plain arithmetic on the digits.
  task automatic issue();
    exp_t e;
    int s = 0;
    bit cerr = 0;
    e.frame = '0;
    for (int i = 0; i <= NDIG; i++) begin
      int dv = 0;
      if (w_det[i]) cerr = 1;
      else for (int k = 0; k < 10; k++) if (enc[k] == w_code[i]) dv = k;
      s += dv;
      if (i < NDIG) e.frame[W-1-4*i -: 4] = 4'(dv);
    end
    e.err = {(!cerr && (s % 10 != 0)), cerr};
    e.cnt = model_cnt;
    q.push_back(e);
    if (e.err != 2'b00 && model_cnt < 255) model_cnt++;
  endtask

  // kind: 0 good, 1 checksum error, 2 code error
  task automatic fill_random(input int kind);
    int s = 0;
    int ck;
    for (int i = 0; i < NDIG; i++) begin
      int d = $urandom_range(0, 9);
      s += d;
      w_code[i] = enc[d];
      w_det[i]  = 1'b0;
    end
    ck = (10 - (s % 10)) % 10;
    if (kind == 1) ck = (ck + $urandom_range(1, 9)) % 10;
    w_code[NDIG] = enc[ck];
    w_det[NDIG]  = 1'b0;
    if (kind == 2) begin
      int pos = $urandom_range(0, NDIG);
      logic [4:0] c;
      do c = 5'($urandom_range(0, 31)); while ($countones(c) == 2);
      w_code[pos] = c;
      w_det[pos]  = 1'b1;
    end
  endtask

  task automatic fill_12345(input int ck);
    for (int i = 0; i < NDIG; i++) begin
      w_code[i] = enc[i+1];
      w_det[i]  = 1'b0;
    end
    w_code[NDIG] = enc[ck];
    w_det[NDIG]  = 1'b0;
  endtask

  // Called and returns at posedge+1.
  task automatic send_word(input logic [4:0] c, input logic d, input logic sof, input bit gap);
    int t = 0;
    bit r;
    IN_VALID = 1'b0;
    if (gap) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    CODE_IN = c; DET_IN = d; IN_SOF = sof; IN_VALID = 1'b1;
    forever begin
      r = IN_READY;
      @(posedge CLK); #1;
      if (r) break;
      if (++t > 300) begin
        checks++; errors++;
        $display("FAIL word_accept_timeout at %0t", $time);
        break;
      end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic send_frame(input int nwords, input bit gap);
    for (int i = 0; i < nwords; i++) send_word(w_code[i], w_det[i], i == 0, gap);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 || FRAME_VALID) begin
      @(posedge CLK); #1;
      if (++t > 2000) begin
        checks++; errors++;
        $display("FAIL drain_timeout pending %0d at %0t", q.size(), $time);
        break;
      end
    end
  endtask

  // Consumer: random acceptance unless a test takes manual control.
  initial forever begin
    @(negedge CLK);
    FRAME_READY = bp ? bp_rdy : ($urandom_range(0, 3) != 0);
  end

  // Monitor: a new frame is a rising FRAME_VALID; while held it must not move.
  initial begin
    bit   prev_v = 0;
    exp_t cur;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_v = 0;
      end else if (FRAME_VALID && !prev_v) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame got %0h at %0t", FRAME, $time);
        end else begin
          cur = q.pop_front();
          chk("frame", 64'(FRAME), 64'(cur.frame));
          chk("frame_err", 64'(FRAME_ERR), 64'(cur.err));
          chk("err_cnt", 64'(ERR_CNT), 64'(cur.cnt));
        end
        prev_v = 1;
      end else if (FRAME_VALID) begin
        chk("frame_stable", 64'({FRAME_ERR, FRAME}), 64'({cur.err, cur.frame}));
      end else begin
        prev_v = 0;
      end
    end
  end

  initial begin
    #3;
    chk("rst_in_ready", 64'(IN_READY), 64'd1);
    chk("rst_valid", 64'(FRAME_VALID), 64'd0);
    chk("rst_frame", 64'(FRAME), 64'd0);
    chk("rst_cnt", 64'(ERR_CNT), 64'd0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;

    // Directed: good, checksum error, code error (third word).
    fill_12345(5); issue(); send_frame(NDIG+1, 1);
    fill_12345(4); issue(); send_frame(NDIG+1, 1);
    fill_12345(5); w_code[2] = 5'b00111; w_det[2] = 1'b1; issue(); send_frame(NDIG+1, 1);
    drain();
    chk("cnt_after_directed", 64'(ERR_CNT), 64'(model_cnt));

    // Backpressure with a word waiting upstream.
    bp = 1; bp_rdy = 0;
    fill_12345(5); issue(); send_frame(NDIG+1, 0);
    chk("valid_latency", 64'(FRAME_VALID), 64'd1);
    CODE_IN = enc[7]; DET_IN = 0; IN_SOF = 0; IN_VALID = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("bp_in_ready", 64'(IN_READY), 64'd0);
      chk("bp_valid", 64'(FRAME_VALID), 64'd1);
    end
    bp_rdy = 1;
    @(posedge CLK); #1;
    chk("bp_release_ready", 64'(IN_READY), 64'd1);
    chk("bp_release_valid", 64'(FRAME_VALID), 64'd0);
    bp = 0; bp_rdy = 0;
    @(posedge CLK); #1;
    IN_VALID = 0;

    // Drops in IDLE and mid-frame resync.
    send_word(enc[3], 0, 0, 1);
    send_word(enc[8], 0, 0, 1);
    fill_random(0); send_frame(3, 1);
    fill_random(0); issue(); send_frame(NDIG+1, 1);
    drain();
    chk("cnt_after_resync", 64'(ERR_CNT), 64'(model_cnt));

    // Reset mid-frame.
    fill_random(0); send_frame(3, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(IN_READY), 64'd1);
    chk("mid_rst_valid", 64'(FRAME_VALID), 64'd0);
    chk("mid_rst_frame", 64'(FRAME), 64'd0);
    chk("mid_rst_err", 64'(FRAME_ERR), 64'd0);
    chk("mid_rst_cnt", 64'(ERR_CNT), 64'd0);
    model_cnt = 0;
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;

    // Random mix with noise words between frames.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) send_word(enc[$urandom_range(0, 9)], 0, 0, 1);
      if ($urandom_range(0, 5) == 0) begin fill_random(0); send_frame($urandom_range(1, NDIG), 1); end
      fill_random($urandom_range(0, 2)); issue(); send_frame(NDIG+1, 1);
    end
    drain();
    chk("cnt_after_random", 64'(ERR_CNT), 64'(model_cnt));

    // Saturation.
    for (int n = 0; n < 260; n++) begin
      fill_random($urandom_range(1, 2)); issue(); send_frame(NDIG+1, 0);
    end
    drain();
    chk("cnt_saturated", 64'(ERR_CNT), 64'd255);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
